sifive_hs_protocol_monitor: RTL
===============================

SIFIVE_HS_PROTOCOL_MONITOR -- requirements
Module: sifive_hs_protocol_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of monitored valid/ready channels (legal 1..16).
REQ-002 SHALL have parameter DATA_W, default 32, payload width per channel (legal 1..64).
REQ-003 SHALL have parameter MAX_WAIT, default 255, stall cycles before timeout; 0 disables the timeout check.
REQ-004 SHALL have parameter CNT_W, default 8, width of the violation counter.
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  checking enabled when high.
REQ-008 clear  input  1  synchronous clear of sticky error state.
REQ-009 ch_valid  input  N_CH  per-channel valid.
REQ-010 ch_ready  input  N_CH  per-channel ready.
REQ-011 ch_data  input  N_CH*DATA_W  payloads; channel i at bits [i*DATA_W +: DATA_W].
REQ-012 err_valid_drop  output  N_CH  sticky: valid deasserted before handshake.
REQ-013 err_data_change  output  N_CH  sticky: payload changed while stalled.
REQ-014 err_timeout  output  N_CH  sticky: stall reached MAX_WAIT cycles.
REQ-015 err_any  output  1  OR of all sticky flags.
REQ-016 first_err_ch  output  max(1,$clog2(N_CH))  channel of first recorded violation.
REQ-017 first_err_code  output  2  01 valid_drop, 10 data_change, 11 timeout, 00 none.
REQ-018 err_count  output  CNT_W  saturating count of cycles with at least one new violation.
REQ-019 fire  output  1  one-cycle registered pulse the cycle after any new violation.

Function
REQ-020 SHALL keep per channel a state IDLE/STALL, a DATA_W payload capture register and a wait counter of width $clog2(MAX_WAIT+1).
REQ-021 IDLE->STALL when enable & valid & !ready; payload captured, wait counter loaded with 1.
REQ-022 STALL->IDLE when valid & ready (handshake; payload checked against capture same cycle).
REQ-023 In STALL, valid low SHALL flag valid_drop and return to IDLE.
REQ-024 In STALL, valid high with ch_data != capture SHALL flag data_change; capture updated to new data, state remains STALL.
REQ-025 In STALL with valid & !ready, wait counter increments; when counter == MAX_WAIT (MAX_WAIT>0) timeout flags once per stall episode; counter holds, no re-flag until IDLE.
REQ-026 valid_drop takes precedence over data_change on the same channel in the same cycle; timeout and data_change may flag together.
REQ-027 Violation detected combinationally in cycle T; sticky flags, first_err_*, err_count and fire update at edge ending T (visible T+1); fire high only in T+1.
REQ-028 first_err_ch/code SHALL latch only while err_any is 0; simultaneous channels resolve to lowest index; on one channel code priority timeout > data_change > valid_drop.
REQ-029 err_count increments by exactly 1 per violating cycle regardless of how many channels; saturates at 2^CNT_W-1.
REQ-030 clear high: sticky flags, first_err_*, err_count to 0; a violation in the same cycle is then recorded as new (post-clear values reflect only it); channel state machines unaffected.
REQ-031 enable low: all channels forced to IDLE, counters to 0, no violations detected; sticky outputs hold.
REQ-032 Channels SHALL be fully independent except for shared first_err/count/fire logic.

Reset
REQ-033 reset_n low SHALL asynchronously set all outputs to 0, all channels to IDLE, all wait counters and captures to 0.
REQ-034 reset_n deassertion mid-stall SHALL NOT flag; the first checked cycle is the first rising edge with reset_n high.

Verification
REQ-035 ch0 valid=1 ready=0 data=0xA5 for 3 cycles then ready=1 -> no flags, err_count=0, fire never high.
REQ-036 ch2 stalls with data=0x10 then data=0x11 next cycle -> err_data_change=0b0100, first_err_ch=2, code=10, fire one cycle, err_count=1.
REQ-037 MAX_WAIT=4, ch1 valid=1 ready=0 held 10 cycles -> err_timeout[1] set after 4th stall cycle, err_count=1 (not re-incremented).
REQ-038 ch3 and ch1 both drop valid mid-stall same cycle -> err_valid_drop=0b1010, first_err_ch=1, code=01, err_count=1.
REQ-039 CNT_W=2, 5 separate violating cycles -> err_count saturates at 3; clear pulse -> all error outputs 0 next cycle.
REQ-040 reset_n pulled low during ch0 stall with err_any=1 -> all outputs 0 immediately (no clock); after release, valid held with new data -> no flag until a fresh stall.

Source files
------------

// File: rtl/sifive_hs_protocol_monitor.sv
// Valid/ready handshake protocol monitor: flags dropped valid, payload change
// while stalled and stall timeouts per channel, with sticky flags and a shared first-error log.
module sifive_hs_protocol_monitor #(
  parameter int N_CH     = 4,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 8,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [N_CH-1:0]          ch_valid,
  input  logic [N_CH-1:0]          ch_ready,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  output logic [N_CH-1:0]          err_valid_drop,
  output logic [N_CH-1:0]          err_data_change,
  output logic [N_CH-1:0]          err_timeout,
  output logic                     err_any,
  output logic [CH_W-1:0]          first_err_ch,
  output logic [1:0]               first_err_code,
  output logic [CNT_W-1:0]         err_count,
  output logic                     fire
);

  localparam int WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WCW-1:0] WMAX = WCW'(MAX_WAIT);

  typedef enum logic {IDLE, STALL} ch_state_t;

  ch_state_t         state_q [N_CH];
  ch_state_t         state_d [N_CH];
  logic [DATA_W-1:0] cap_q   [N_CH];
  logic [DATA_W-1:0] cap_d   [N_CH];
  logic [WCW-1:0]    wcnt_q  [N_CH];
  logic [WCW-1:0]    wcnt_d  [N_CH];

  logic [N_CH-1:0]   vd_new, dc_new, to_new;
  logic              any_new;
  logic [CH_W-1:0]   fch;
  logic [1:0]        fcode;

  // Per-channel handshake tracking and violation detection
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cap_d[i]   = cap_q[i];
      wcnt_d[i]  = wcnt_q[i];
      vd_new[i]  = 1'b0;
      dc_new[i]  = 1'b0;
      to_new[i]  = 1'b0;
      if (!enable) begin
        state_d[i] = IDLE;
        wcnt_d[i]  = '0;
      end else if (state_q[i] == IDLE) begin
        if (ch_valid[i] && !ch_ready[i]) begin
          state_d[i] = STALL;
          cap_d[i]   = ch_data[i*DATA_W +: DATA_W];
          wcnt_d[i]  = WCW'(1);
          // A one-cycle limit is already reached on the stall's first cycle
          to_new[i]  = (MAX_WAIT == 1);
        end
      end else if (!ch_valid[i]) begin
        vd_new[i]  = 1'b1;
        state_d[i] = IDLE;
        wcnt_d[i]  = '0;
      end else begin
        dc_new[i] = (ch_data[i*DATA_W +: DATA_W] != cap_q[i]);
        if (ch_ready[i]) begin
          state_d[i] = IDLE;
          wcnt_d[i]  = '0;
        end else begin
          cap_d[i] = ch_data[i*DATA_W +: DATA_W];
          // Counter parks at the limit so a timeout fires once per stall episode
          if (MAX_WAIT > 0 && wcnt_q[i] != WMAX) begin
            wcnt_d[i] = wcnt_q[i] + WCW'(1);
            to_new[i] = ((wcnt_q[i] + WCW'(1)) == WMAX);
          end
        end
      end
    end
  end

  assign any_new = |{vd_new, dc_new, to_new};

  // Lowest-indexed violating channel wins; on one channel timeout outranks data change
  always_comb begin
    fch   = '0;
    fcode = 2'b00;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (vd_new[i] || dc_new[i] || to_new[i]) begin
        fch   = CH_W'(i);
        fcode = to_new[i] ? 2'b11 : (dc_new[i] ? 2'b10 : 2'b01);
      end
    end
  end

  assign err_any = |{err_valid_drop, err_data_change, err_timeout};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= IDLE;
        cap_q[i]   <= '0;
        wcnt_q[i]  <= '0;
      end
      err_valid_drop  <= '0;
      err_data_change <= '0;
      err_timeout     <= '0;
      first_err_ch    <= '0;
      first_err_code  <= 2'b00;
      err_count       <= '0;
      fire            <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cap_q[i]   <= cap_d[i];
        wcnt_q[i]  <= wcnt_d[i];
      end
      // Clear discards history; a violation in the clearing cycle starts the new record
      if (clear) begin
        err_valid_drop  <= vd_new;
        err_data_change <= dc_new;
        err_timeout     <= to_new;
      end else begin
        err_valid_drop  <= err_valid_drop  | vd_new;
        err_data_change <= err_data_change | dc_new;
        err_timeout     <= err_timeout     | to_new;
      end
      if (any_new && (clear || !err_any)) begin
        first_err_ch   <= fch;
        first_err_code <= fcode;
      end else if (clear) begin
        first_err_ch   <= '0;
        first_err_code <= 2'b00;
      end
      if (clear) begin
        err_count <= any_new ? CNT_W'(1) : '0;
      end else if (any_new && err_count != '1) begin
        err_count <= err_count + CNT_W'(1);
      end
      fire <= any_new;
    end
  end

endmodule
